frog_hop_ctrl: RTL and testbench
================================

# frog_hop_ctrl

Sequencer that turns raw keyboard direction levels into discrete, fixed-length frog hops. It also runs the life/death/respawn cycle. It sits between the keyboard decoder and the frog movement datapath. It drives that datapath's left/right/up/down and reset_position inputs, and it counts timer_done ticks so that every hop moves the frog exactly one frog-size step.

## Interface
Parameters:
- HOP_TICKS, 10: timer_done ticks per hop (10 × 2 px = 20 px, one frog size)
- COOLDOWN_TICKS, 4: ticks after a hop before a new key is accepted
- DEATH_TICKS, 60: ticks spent in the death animation
- LIVES, 3: lives loaded at game start (1..3)

Ports:
- CLK  in  1  system clock
- RESETn  in  1  asynchronous, active-low reset
- timer_done  in  1  one-cycle movement tick, shared with the datapath
- key_up, key_down, key_left, key_right  in  1 each  debounced key levels
- collision  in  1  frog hit car or water, level
- goal_reached  in  1  frog reached the far bank, level
- game_start  in  1  start/restart request, level
- move_up, move_down, move_left, move_right  out  1 each  drive the datapath direction inputs
- reset_position  out  1  one-cycle pulse that returns the frog to its start position
- hopping  out  1  high in HOP
- dead  out  1  high in DYING
- game_over  out  1  high in GAME_OVER
- score_pulse  out  1  one-cycle pulse per goal
- lives  out  2  remaining lives

## Operation
- States: IDLE, READY, HOP, COOLDOWN, DYING, GAME_OVER. All outputs are registered.
- Reset state: IDLE. All outputs 0 except lives, which resets to LIVES.
- IDLE or GAME_OVER + game_start: lives ← LIVES, pulse reset_position, go to READY.
- READY:
  - Any key high: latch one direction, load tick counter 0, go to HOP.
  - Key priority: up > down > left > right.
- HOP:
  - The latched move_* is held high. Keys are ignored.
  - The counter increments on each timer_done. On the edge where it reaches HOP_TICKS, move_* drops and the state goes to COOLDOWN.
- COOLDOWN: count COOLDOWN_TICKS timer_done pulses, then go to READY. A key held through COOLDOWN starts a new hop immediately on entering READY (auto-repeat).
- Collision (in READY, HOP or COOLDOWN):
  - Go to DYING, drop move_* and decrement lives, all on the same edge.
  - After DEATH_TICKS ticks: pulse reset_position. Go to READY if lives > 0, else GAME_OVER.
- goal_reached (in READY, HOP or COOLDOWN): pulse score_pulse and reset_position together, drop move_*, go to READY.
- Same-cycle conflicts:
  - collision and goal_reached together: collision wins, no score.
  - collision and a key in READY: collision wins.
  - Collision or goal_reached in DYING, IDLE or GAME_OVER: ignored.
- lives saturates at 0 and never wraps.
- The tick counter is 7 bits, sized for DEATH_TICKS ≤ 127. It is cleared on every state entry.

## Timing
- Key to motion: a key sampled in READY at edge N raises move_* at edge N (visible in cycle N+1).
- A timer_done coincident with edge N is not counted.
- The datapath samples move_* on timer_done. The final counted tick is sampled while move_* is still high, so each uninterrupted hop produces exactly HOP_TICKS datapath moves.
- reset_position and score_pulse are exactly one cycle wide.
- Collision-to-stop latency is one edge: no datapath move occurs on a tick one cycle or more after collision is registered.
- RESETn mid-hop: asynchronous return to IDLE, move_* low immediately, lives = LIVES.

## Structure
- Package frog_ctrl_pkg:
  - state enum (6 states)
  - direction enum (NONE, UP, DOWN, LEFT, RIGHT)
  - default tick constants
- Single module, no sub-modules.
- The tick counter and the direction-priority encoder are inline.

## Test plan
- Reset, game_start pulse: reset_position for 1 cycle, lives = 3, state READY.
- key_up held 1 cycle, 15 timer_done pulses: move_up high for exactly 10 ticks. Datapath Y advances 20 px, then COOLDOWN for 4 ticks.
- key_up and key_left high together in READY: only move_up asserts.
- Collision at tick 5 of a hop: move_up drops next edge, lives 3→2. After 60 ticks, reset_position pulse and READY.
- Three collisions: lives reaches 0, GAME_OVER asserted and held. game_start restores lives = 3.
- collision and goal_reached in the same cycle: no score_pulse, lives decremented. goal_reached alone: score_pulse and reset_position coincide for 1 cycle.

Source files
------------

// File: rtl/frog_ctrl_pkg.sv
// Shared types and default tick counts for the frog hop sequencer.
// State and direction encodings are internal to frog_hop_ctrl.
package frog_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_HOP,
    ST_COOLDOWN,
    ST_DYING,
    ST_GAME_OVER
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam int DEF_HOP_TICKS      = 10;
  localparam int DEF_COOLDOWN_TICKS = 4;
  localparam int DEF_DEATH_TICKS    = 60;
  localparam int DEF_LIVES          = 3;
  localparam int CNT_W              = 7;

endpackage

// File: rtl/frog_hop_ctrl.sv
// Turns key levels into fixed-length hops and runs the life/death/respawn cycle.
// All outputs registered; a key sampled in READY drives move_* from the next cycle.
module frog_hop_ctrl
  import frog_ctrl_pkg::*;
#(
  parameter int HOP_TICKS      = DEF_HOP_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int DEATH_TICKS    = DEF_DEATH_TICKS,
  parameter int LIVES          = DEF_LIVES
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       timer_done,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       collision,
  input  logic       goal_reached,
  input  logic       game_start,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       reset_position,
  output logic       hopping,
  output logic       dead,
  output logic       game_over,
  output logic       score_pulse,
  output logic [1:0] lives
);

  state_t             state;
  dir_t               key_dir;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               in_play;

  always_comb begin
    key_dir = DIR_NONE;
    if (key_up)         key_dir = DIR_UP;
    else if (key_down)  key_dir = DIR_DOWN;
    else if (key_left)  key_dir = DIR_LEFT;
    else if (key_right) key_dir = DIR_RIGHT;
  end

  assign cnt_inc = cnt + 1'b1;
  assign in_play = (state == ST_READY) || (state == ST_HOP) || (state == ST_COOLDOWN);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      move_up        <= 1'b0;
      move_down      <= 1'b0;
      move_left      <= 1'b0;
      move_right     <= 1'b0;
      reset_position <= 1'b0;
      hopping        <= 1'b0;
      dead           <= 1'b0;
      game_over      <= 1'b0;
      score_pulse    <= 1'b0;
      lives          <= 2'(LIVES);
    end else begin
      reset_position <= 1'b0;
      score_pulse    <= 1'b0;
      // Collision outranks goal and keys; both stop motion on this same edge.
      if (in_play && collision) begin
        state      <= ST_DYING;
        cnt        <= '0;
        move_up    <= 1'b0;
        move_down  <= 1'b0;
        move_left  <= 1'b0;
        move_right <= 1'b0;
        hopping    <= 1'b0;
        dead       <= 1'b1;
        lives      <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
      end else if (in_play && goal_reached) begin
        state          <= ST_READY;
        cnt            <= '0;
        move_up        <= 1'b0;
        move_down      <= 1'b0;
        move_left      <= 1'b0;
        move_right     <= 1'b0;
        hopping        <= 1'b0;
        score_pulse    <= 1'b1;
        reset_position <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_GAME_OVER: begin
            if (game_start) begin
              state          <= ST_READY;
              cnt            <= '0;
              lives          <= 2'(LIVES);
              reset_position <= 1'b1;
              game_over      <= 1'b0;
            end
          end
          ST_READY: begin
            if (key_dir != DIR_NONE) begin
              state      <= ST_HOP;
              cnt        <= '0;
              hopping    <= 1'b1;
              move_up    <= (key_dir == DIR_UP);
              move_down  <= (key_dir == DIR_DOWN);
              move_left  <= (key_dir == DIR_LEFT);
              move_right <= (key_dir == DIR_RIGHT);
            end
          end
          ST_HOP: begin
            // The final tick is still seen by the datapath with move_* high.
            if (timer_done) begin
              if (cnt_inc == CNT_W'(HOP_TICKS)) begin
                state      <= ST_COOLDOWN;
                cnt        <= '0;
                hopping    <= 1'b0;
                move_up    <= 1'b0;
                move_down  <= 1'b0;
                move_left  <= 1'b0;
                move_right <= 1'b0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          ST_COOLDOWN: begin
            if (timer_done) begin
              if (cnt_inc == CNT_W'(COOLDOWN_TICKS)) begin
                state <= ST_READY;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          ST_DYING: begin
            if (timer_done) begin
              if (cnt_inc == CNT_W'(DEATH_TICKS)) begin
                cnt            <= '0;
                dead           <= 1'b0;
                reset_position <= 1'b1;
                if (lives != 2'd0) begin
                  state <= ST_READY;
                end else begin
                  state     <= ST_GAME_OVER;
                  game_over <= 1'b1;
                end
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed-plus-random bench for frog_hop_ctrl against a datapath position model.
module tb_frog_hop_ctrl;

  localparam int HOP = 10;
  localparam int CD  = 4;
  localparam int DT  = 60;
  localparam int NL  = 3;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       timer_done = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       collision = 1'b0, goal_reached = 1'b0, game_start = 1'b0;
  logic       move_up, move_down, move_left, move_right;
  logic       reset_position, hopping, dead, game_over, score_pulse;
  logic [1:0] lives;

  int checks = 0;
  int failures = 0;
  int dp_x = 0;
  int dp_y = 0;
  int exp_lives = NL;

  always #5 CLK = ~CLK;

  frog_hop_ctrl #(
    .HOP_TICKS(HOP), .COOLDOWN_TICKS(CD), .DEATH_TICKS(DT), .LIVES(NL)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .timer_done(timer_done),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .collision(collision), .goal_reached(goal_reached), .game_start(game_start),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .reset_position(reset_position), .hopping(hopping), .dead(dead),
    .game_over(game_over), .score_pulse(score_pulse), .lives(lives)
  );

  // Datapath: each timer_done moves the frog 2 px in every asserted direction.
  always @(posedge CLK) begin
    if (timer_done) begin
      if (move_up)    dp_y <= dp_y + 2;
      if (move_down)  dp_y <= dp_y - 2;
      if (move_left)  dp_x <= dp_x - 2;
      if (move_right) dp_x <= dp_x + 2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] prio(input logic [3:0] m);
    if (m[3]) return 4'b1000;
    if (m[2]) return 4'b0100;
    if (m[1]) return 4'b0010;
    if (m[0]) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] mv();
    return {move_up, move_down, move_left, move_right};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic tick();
    repeat ($urandom_range(0, 2)) cyc();
    timer_done = 1'b1;
    cyc();
    timer_done = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_keys(input logic [3:0] m);
    {key_up, key_down, key_left, key_right} = m;
  endtask

  task automatic respawn(input string tag);
    ticks(DT - 1);
    check({tag, "_dead_held"}, dead, 1);
    check({tag, "_no_early_rp"}, reset_position, 0);
    tick();
    check({tag, "_rp_pulse"}, reset_position, 1);
    check({tag, "_dead_clear"}, dead, 0);
    check({tag, "_game_over"}, game_over, (exp_lives == 0) ? 1 : 0);
    cyc();
    check({tag, "_rp_width"}, reset_position, 0);
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] e;
    int x0, y0, dx, dy;

    @(negedge CLK);
    check("rst_moves", mv(), 0);
    check("rst_rp", reset_position, 0);
    check("rst_flags", {hopping, dead, game_over, score_pulse}, 0);
    check("rst_lives", lives, NL);
    RESETn = 1'b1;
    cyc();

    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    check("start_rp", reset_position, 1);
    check("start_lives", lives, NL);
    cyc();
    check("start_rp_width", reset_position, 0);

    // Hops: first with up+left together, then random key combinations.
    for (int it = 0; it < 6; it++) begin
      m = (it == 0) ? 4'b1010 : 4'($urandom_range(1, 15));
      e = prio(m);
      x0 = dp_x; y0 = dp_y;
      set_keys(m);
      cyc();
      set_keys(4'b0000);
      check("hop_dir", mv(), e);
      check("hop_flag", hopping, 1);
      ticks(HOP - 1);
      check("hop_still", mv(), e);
      tick();
      check("hop_end_moves", mv(), 0);
      check("hop_end_flag", hopping, 0);
      dx = e[0] ? 2 * HOP : (e[1] ? -2 * HOP : 0);
      dy = e[3] ? 2 * HOP : (e[2] ? -2 * HOP : 0);
      check("hop_dx", dp_x - x0, dx);
      check("hop_dy", dp_y - y0, dy);
      ticks(CD - 1);
      set_keys(4'($urandom_range(1, 15)));
      cyc();
      set_keys(4'b0000);
      check("cooldown_ignores_key", hopping, 0);
      tick();
    end

    // Auto-repeat: key held through cooldown.
    set_keys(4'b0001);
    cyc();
    check("rep_first", mv(), 4'b0001);
    ticks(HOP + CD);
    check("rep_ready", hopping, 0);
    cyc();
    check("rep_again", mv(), 4'b0001);
    set_keys(4'b0000);
    ticks(HOP + CD);

    // Collision at tick 5 of an up hop.
    y0 = dp_y;
    set_keys(4'b1000);
    cyc();
    set_keys(4'b0000);
    ticks(5);
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    exp_lives--;
    check("col_moves", mv(), 0);
    check("col_dead", dead, 1);
    check("col_lives", lives, exp_lives);
    respawn("col1");
    check("col_dy", dp_y - y0, 10);

    // Two more collisions from READY lead to GAME_OVER.
    for (int k = 0; k < 2; k++) begin
      collision = 1'b1;
      cyc();
      collision = 1'b0;
      exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0;
      check("col_more_lives", lives, exp_lives);
      check("col_more_dead", dead, 1);
      respawn("col_more");
    end
    collision = 1'b1;
    key_up = 1'b1;
    cyc();
    collision = 1'b0;
    key_up = 1'b0;
    check("go_lives_sat", lives, 0);
    check("go_held", game_over, 1);
    check("go_no_hop", {hopping, dead}, 0);
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
    exp_lives = NL;
    check("restart_lives", lives, exp_lives);
    check("restart_go", game_over, 0);
    check("restart_rp", reset_position, 1);
    cyc();

    // Collision and goal together: collision wins.
    collision = 1'b1;
    goal_reached = 1'b1;
    cyc();
    collision = 1'b0;
    goal_reached = 1'b0;
    exp_lives--;
    check("both_score", score_pulse, 0);
    check("both_dead", dead, 1);
    check("both_lives", lives, exp_lives);
    respawn("both");

    // Goal alone during a hop.
    set_keys(4'b0010);
    cyc();
    set_keys(4'b0000);
    ticks(3);
    goal_reached = 1'b1;
    cyc();
    goal_reached = 1'b0;
    check("goal_score", score_pulse, 1);
    check("goal_rp", reset_position, 1);
    check("goal_moves", mv(), 0);
    check("goal_lives", lives, exp_lives);
    cyc();
    check("goal_width", {score_pulse, reset_position}, 0);

    // Asynchronous reset mid-hop.
    set_keys(4'b0100);
    cyc();
    set_keys(4'b0000);
    ticks(2);
    check("arst_pre", mv(), 4'b0100);
    #2 RESETn = 1'b0;
    #1;
    check("arst_moves", mv(), 0);
    check("arst_hop", hopping, 0);
    check("arst_lives", lives, NL);
    @(negedge CLK);
    RESETn = 1'b1;
    cyc();
    check("arst_idle", {hopping, dead, game_over, reset_position}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
